sram_access_ctrl: RTL and testbench

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

---
 rtl/sram_access_ctrl_if.sv | 22 ++
 rtl/sram_access_ctrl.sv | 131 +++++++++++++
 tb/tb_sram_access_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// Requester-side command/response bundle for sram_access_ctrl.
// master = requester, slave = controller.
interface sram_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [14:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: single-outstanding access controller that maps a narrow
// logical word (32 >> k bits) onto a 1k x 32 SRAM macro row/lane.
// Optional feature macro: CONF_LOCK_EN -- latch the width config at command
// acceptance instead of using the live conf input throughout.
module sram_access_ctrl (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          conf,
   sram_access_ctrl_if.slave   bus,
   output logic                sram_en,
   output logic                sram_we,
   output logic [9:0]          sram_addr,
   output logic [31:0]         sram_wmask,
   output logic [31:0]         sram_wdata,
   input  logic [31:0]         sram_rdata
);

   typedef enum logic [1:0] {IDLE, ACC, CAP, RESP} state_t;

   state_t      state, state_nx;
   logic        we_q;
   logic [4:0]  lane_q;
   logic [9:0]  row_q;
   logic [31:0] data_q;
   logic [31:0] rdata_q;

   // 110/111 alias to the full-width geometry
   logic [2:0]  k_live;
   logic [2:0]  k_use;
   assign k_live = (conf > 3'd5) ? 3'd0 : conf;

`ifdef CONF_LOCK_EN
   logic [2:0]  conf_q;
   assign k_use = conf_q;
`else
   assign k_use = k_live;
`endif

   // Lane/row split at acceptance: lane is the low k address bits, row the next 10
   logic [4:0]  lane_nx;
   logic [9:0]  row_nx;
   assign lane_nx = bus.req_addr[4:0] & ~(5'h1f << k_live);
   assign row_nx  = 10'(bus.req_addr >> k_live);

   // Geometry helpers: w_m1 = W-1, off = lane*W, base = W low ones
   logic [4:0]  w_m1;
   logic [4:0]  off;
   logic [31:0] base;
   logic [31:0] rep;
   logic [31:0] cap;
   assign w_m1 = 5'd31 >> k_use;
   assign off  = lane_q << (3'd5 - k_use);
   assign base = 32'hffff_ffff >> (~w_m1);
   assign cap  = (sram_rdata >> off) & base;

   // Replicate the low W bits of the write data across all 32 bits
   always_comb begin
      rep = '0;
      for (int i = 0; i < 32; i++) begin
         rep[i] = data_q[5'(i) & w_m1];
      end
   end

   // State and command/response registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         lane_q  <= '0;
         row_q   <= '0;
         data_q  <= '0;
         rdata_q <= '0;
`ifdef CONF_LOCK_EN
         conf_q  <= '0;
`endif
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (bus.req_valid) begin
               we_q    <= bus.req_we;
               lane_q  <= lane_nx;
               row_q   <= row_nx;
               data_q  <= bus.req_wdata;
               rdata_q <= '0;
`ifdef CONF_LOCK_EN
               conf_q  <= k_live;
`endif
            end
            CAP: rdata_q <= cap;
            default: ;
         endcase
      end
   end

   // Next-state and output decode
   always_comb begin
      state_nx       = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = '0;
      sram_en        = 1'b0;
      sram_we        = 1'b0;
      sram_addr      = '0;
      sram_wmask     = '0;
      sram_wdata     = '0;
      case (state)
         IDLE: begin
            bus.req_ready = rst_n;
            if (bus.req_valid) state_nx = ACC;
         end
         ACC: begin
            sram_en   = 1'b1;
            sram_we   = we_q;
            sram_addr = row_q;
            if (we_q) begin
               sram_wmask = base << off;
               sram_wdata = rep;
            end
            state_nx = we_q ? RESP : CAP;
         end
         CAP: state_nx = RESP;
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_rdata = rdata_q;
            if (bus.resp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed, table-driven bench for sram_access_ctrl plus hand-written
// stall and mid-operation reset sequences.
module tb_sram_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  conf;
   logic        sram_en, sram_we;
   logic [9:0]  sram_addr;
   logic [31:0] sram_wmask, sram_wdata, sram_rdata;

   sram_access_ctrl_if bus ();

   sram_access_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .conf       (conf),
      .bus        (bus),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wmask (sram_wmask),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  conf;
      logic        we;
      logic [14:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [9:0]  eaddr;
      logic [31:0] emask;
      logic [31:0] ewdata;
      logic [31:0] eresp;
   } vec_t;

   localparam int NV = 11;
   vec_t vt [NV];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // One full transaction with resp_ready held high, checked cycle by cycle
   task automatic run_vec(input int i);
      vec_t v;
      v = vt[i];
      @(negedge clk);                                   // cycle N
      chk($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'd1);
      conf          = v.conf;
      bus.req_valid = 1'b1;
      bus.req_we    = v.we;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      @(negedge clk);                                   // cycle N+1 (ACC)
      bus.req_valid = 1'b0;
      bus.req_addr  = 15'h7abc;
      bus.req_wdata = 32'h5555_aaaa;
      chk($sformatf("v%0d sram_en", i),    32'(sram_en),   32'd1);
      chk($sformatf("v%0d sram_we", i),    32'(sram_we),   32'(v.we));
      chk($sformatf("v%0d sram_addr", i),  32'(sram_addr), 32'(v.eaddr));
      chk($sformatf("v%0d sram_wmask", i), sram_wmask,     v.emask);
      chk($sformatf("v%0d sram_wdata", i), sram_wdata,     v.ewdata);
      chk($sformatf("v%0d early_resp", i), 32'(bus.resp_valid), 32'd0);
      @(negedge clk);                                   // cycle N+2
      chk($sformatf("v%0d sram_en_off", i), 32'(sram_en), 32'd0);
      chk($sformatf("v%0d wmask_off", i),   sram_wmask,   32'd0);
      if (v.we) begin
         chk($sformatf("v%0d resp_valid", i), 32'(bus.resp_valid), 32'd1);
         chk($sformatf("v%0d resp_rdata", i), bus.resp_rdata,      32'd0);
      end else begin
         chk($sformatf("v%0d resp_early", i), 32'(bus.resp_valid), 32'd0);
         sram_rdata = v.rdata;
         @(negedge clk);                                // cycle N+3
         sram_rdata = 32'h0;
         chk($sformatf("v%0d resp_valid", i), 32'(bus.resp_valid), 32'd1);
         chk($sformatf("v%0d resp_rdata", i), bus.resp_rdata,      v.eresp);
      end
   endtask

   initial begin
      //            conf  we    addr      wdata          rdata          eaddr    emask          ewdata         eresp
      vt[0]  = '{3'd0, 1'b1, 15'h0005, 32'hdeadbeef, 32'h0,        10'h005, 32'hffffffff, 32'hdeadbeef, 32'h0};
      vt[1]  = '{3'd2, 1'b1, 15'h0007, 32'h123456a5, 32'h0,        10'h001, 32'hff000000, 32'ha5a5a5a5, 32'h0};
      vt[2]  = '{3'd2, 1'b0, 15'h0007, 32'h0,        32'ha5123456, 10'h001, 32'h0,        32'h0,        32'h000000a5};
      vt[3]  = '{3'd5, 1'b1, 15'h7fff, 32'h00000001, 32'h0,        10'h3ff, 32'h80000000, 32'hffffffff, 32'h0};
      vt[4]  = '{3'd7, 1'b0, 15'h0403, 32'h0,        32'hcafef00d, 10'h003, 32'h0,        32'h0,        32'hcafef00d};
      vt[5]  = '{3'd1, 1'b1, 15'h0803, 32'h99991234, 32'h0,        10'h001, 32'hffff0000, 32'h12341234, 32'h0};
      vt[6]  = '{3'd3, 1'b0, 15'h0015, 32'h0,        32'h76543210, 10'h002, 32'h0,        32'h0,        32'h00000005};
      vt[7]  = '{3'd4, 1'b1, 15'h0006, 32'hfffffffe, 32'h0,        10'h000, 32'h00003000, 32'haaaaaaaa, 32'h0};
      vt[8]  = '{3'd4, 1'b0, 15'h0009, 32'h0,        32'h000c0000, 10'h000, 32'h0,        32'h0,        32'h00000003};
      vt[9]  = '{3'd5, 1'b0, 15'h0020, 32'h0,        32'hfffffffe, 10'h001, 32'h0,        32'h0,        32'h00000000};
      vt[10] = '{3'd5, 1'b0, 15'h003f, 32'h0,        32'h80000000, 10'h001, 32'h0,        32'h0,        32'h00000001};

      rst_n          = 1'b0;
      conf           = 3'd0;
      sram_rdata     = 32'h0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst req_ready",  32'(bus.req_ready),  32'd0);
      chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst resp_rdata", bus.resp_rdata,      32'd0);
      chk("rst sram_en",    32'(sram_en),        32'd0);
      chk("rst sram_wmask", sram_wmask,          32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel req_ready",  32'(bus.req_ready),  32'd1);

      for (int i = 0; i < NV; i++) run_vec(i);

      // Stalled read response
      @(negedge clk);
      bus.resp_ready = 1'b0;
      conf           = 3'd0;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_addr   = 15'h0012;
      @(negedge clk);
      bus.req_valid  = 1'b0;
      @(negedge clk);
      sram_rdata     = 32'h1234_5678;
      @(negedge clk);
      sram_rdata     = 32'h0;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d resp_valid", c), 32'(bus.resp_valid), 32'd1);
         chk($sformatf("stall%0d resp_rdata", c), bus.resp_rdata,      32'h1234_5678);
         chk($sformatf("stall%0d req_ready", c),  32'(bus.req_ready),  32'd0);
         chk($sformatf("stall%0d sram_en", c),    32'(sram_en),        32'd0);
         @(negedge clk);
      end
      chk("stall still_valid", 32'(bus.resp_valid), 32'd1);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      chk("stall hs req_ready",  32'(bus.req_ready),  32'd1);
      chk("stall hs resp_valid", 32'(bus.resp_valid), 32'd0);

      // Reset during ACC aborts the access
      conf          = 3'd0;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 15'h0055;
      bus.req_wdata = 32'hffff_ffff;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("abort acc sram_en", 32'(sram_en), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort sram_en",    32'(sram_en),        32'd0);
      chk("abort sram_addr",  32'(sram_addr),      32'd0);
      chk("abort sram_wdata", sram_wdata,          32'd0);
      chk("abort req_ready",  32'(bus.req_ready),  32'd0);
      chk("abort resp_valid", 32'(bus.resp_valid), 32'd0);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("post%0d req_ready", c),  32'(bus.req_ready),  32'd1);
         chk($sformatf("post%0d resp_valid", c), 32'(bus.resp_valid), 32'd0);
      end

`ifdef CONF_LOCK_EN
      // Config change mid-read must not move the lane
      conf          = 3'd2;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 15'h0007;
      @(negedge clk);
      bus.req_valid = 1'b0;
      conf          = 3'd0;
      @(negedge clk);
      sram_rdata    = 32'ha512_3456;
      @(negedge clk);
      sram_rdata    = 32'h0;
      chk("lock resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("lock resp_rdata", bus.resp_rdata,      32'h0000_00a5);
      @(negedge clk);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
